// File: rtl/kbd_mode_ctrl.sv
// kbd_mode_ctrl: filters PS/2 bytes, keeps a one-hot editor mode and forwards make codes to the active editor.
// Define MODE_TIMEOUT_EN to build the edit-mode inactivity timeout.
module kbd_mode_ctrl #(
  parameter int unsigned            NUM_MODES   = 4,
  parameter logic [NUM_MODES*8-1:0] MODE_KEYS   = {8'h3A, 8'h32, 8'h4B, 8'h35},
  parameter int unsigned            HOLD_IDX    = 3,
  parameter int unsigned            BLINK_HALF  = 1_250_000,
  parameter int unsigned            TIMEOUT_CYC = 500_000_000
) (
  input  logic                 CLOCK_50,
  input  logic                 nReset,
  input  logic [7:0]           data,
  input  logic                 data_en,
  input  logic                 hold_ok,
  input  logic                 hold_en,
  output logic [NUM_MODES:0]   mode,
  output logic [7:0]           key_code,
  output logic                 key_ext,
  output logic                 key_valid,
  output logic                 start,
  output logic                 abort,
  output logic [NUM_MODES-1:0] led
);

  localparam logic [7:0] BRK_CODE   = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] ENTER_CODE = 8'h5A;
  localparam logic [7:0] ESC_CODE   = 8'h76;

  localparam int unsigned            BW         = $clog2(BLINK_HALF);
  localparam logic [BW-1:0]          BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [NUM_MODES:0]     IDLE_OH    = {{NUM_MODES{1'b0}}, 1'b1};
  localparam logic [NUM_MODES-1:0]   HOLD_LED   = {{(NUM_MODES-1){1'b0}}, 1'b1} << HOLD_IDX;

  logic [NUM_MODES:0]   mode_q, mode_d;
  logic                 brk_pend_q, brk_pend_d;
  logic                 ext_pend_q, ext_pend_d;
  logic                 hold_en_q, hold_en_d;
  logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                 blink_q, blink_d;
  logic [7:0]           key_code_q, key_code_d;
  logic                 key_ext_q, key_ext_d;
  logic                 key_valid_q, key_valid_d;
  logic                 start_q, start_d;
  logic                 abort_q, abort_d;
  logic [NUM_MODES-1:0] led_q, led_d;

  logic                 make;
  logic                 make_ext;
  logic                 hold_fall;
  logic                 state_legal;
  logic                 in_idle;
  logic                 in_hold;
  logic                 in_edit;
  logic                 mode_change;
  logic                 abort_evt;
  logic                 fwd_evt;
  logic                 timeout_hit;
  logic [NUM_MODES-1:0] key_hit;
  logic [NUM_MODES-1:0] key_sel;

  // Byte filter: a pending break swallows the next byte together with any E0 prefix.
  always_comb begin
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    hold_en_d  = hold_en;
    make       = 1'b0;
    make_ext   = ext_pend_q;
    if (data_en) begin
      if (brk_pend_q) begin
        brk_pend_d = 1'b0;
        ext_pend_d = 1'b0;
      end else if (data == BRK_CODE) begin
        brk_pend_d = 1'b1;
      end else if (data == EXT_CODE) begin
        ext_pend_d = 1'b1;
      end else begin
        make       = 1'b1;
        ext_pend_d = 1'b0;
      end
    end
  end

  assign hold_fall = hold_en_q & ~hold_en;

  // Duplicate table entries resolve to the lowest matching index.
  generate
    for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_key
      assign key_hit[gi] = (data == MODE_KEYS[8*gi +: 8]);
      if (gi == 0) begin : g_first
        assign key_sel[gi] = key_hit[gi];
      end else begin : g_rest
        assign key_sel[gi] = key_hit[gi] & ~(|key_hit[gi-1:0]);
      end
    end
  endgenerate

  assign state_legal = $onehot(mode_q);
  assign in_idle     = state_legal & mode_q[0];
  assign in_hold     = state_legal & mode_q[HOLD_IDX+1];
  assign in_edit     = state_legal & ~mode_q[0] & ~mode_q[HOLD_IDX+1];

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      mode_q <= IDLE_OH;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    abort_evt = 1'b0;
    fwd_evt   = 1'b0;
    if (!state_legal) begin
      mode_d = IDLE_OH;
    end else if (in_idle) begin
      if (make && (|key_sel) && (!key_sel[HOLD_IDX] || hold_ok)) begin
        mode_d = {key_sel, 1'b0};
      end
    end else if (in_hold) begin
      if (make && (data == ESC_CODE)) begin
        mode_d    = IDLE_OH;
        abort_evt = 1'b1;
      end else if (hold_fall) begin
        mode_d = IDLE_OH;
      end
    end else if (in_edit) begin
      if (make && (data == ENTER_CODE)) begin
        mode_d = IDLE_OH;
      end else if (make && (data == ESC_CODE)) begin
        mode_d    = IDLE_OH;
        abort_evt = 1'b1;
      end else if (make) begin
        fwd_evt = 1'b1;
      end else if (timeout_hit) begin
        mode_d    = IDLE_OH;
        abort_evt = 1'b1;
      end
    end
  end

  assign mode_change = (mode_d != mode_q);

  // Blink phase restarts on every mode change so a freshly entered mode always starts dark.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (mode_change) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

`ifdef MODE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  logic [31:0] to_cnt_q, to_cnt_d;
  logic        edit_d;

  assign edit_d      = ~mode_d[0] & ~mode_d[HOLD_IDX+1];
  assign timeout_hit = in_edit & ~data_en & (to_cnt_q == TIMEOUT_LAST);

  always_comb begin
    to_cnt_d = to_cnt_q + 32'd1;
    if (!edit_d || data_en || mode_change) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // The limit is meaningless without the counter.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_valid_d = fwd_evt;
    if (fwd_evt) begin
      key_code_d = data;
      key_ext_d  = make_ext;
    end
    abort_d = abort_evt;
    start_d = mode_d[HOLD_IDX+1];
    if (mode_d[HOLD_IDX+1]) begin
      led_d = HOLD_LED;
    end else begin
      led_d = ~(mode_d[NUM_MODES:1] & {NUM_MODES{~blink_d}});
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      brk_pend_q  <= 1'b0;
      ext_pend_q  <= 1'b0;
      hold_en_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_valid_q <= 1'b0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      led_q       <= '1;
    end else begin
      brk_pend_q  <= brk_pend_d;
      ext_pend_q  <= ext_pend_d;
      hold_en_q   <= hold_en_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_valid_q <= key_valid_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      led_q       <= led_d;
    end
  end

  assign mode      = mode_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_valid = key_valid_q;
  assign start     = start_q;
  assign abort     = abort_q;
  assign led       = led_q;

endmodule

// File: tb/tb_kbd_mode_ctrl.sv
// tb_kbd_mode_ctrl: scoreboard bench for kbd_mode_ctrl with a byte-level reference model.
// The model honours MODE_TIMEOUT_EN the same way the design does.
module tb_kbd_mode_ctrl;

  localparam int NM   = 4;
  localparam logic [NM*8-1:0] KEYS = {8'h3A, 8'h32, 8'h4B, 8'h35};
  localparam int HOLD = 3;
  localparam int BH   = 5;
  localparam int TO   = 100;

  logic          clk     = 1'b0;
  logic          nReset  = 1'b0;
  logic [7:0]    data    = 8'h00;
  logic          data_en = 1'b0;
  logic          hold_ok = 1'b0;
  logic          hold_en = 1'b0;
  logic [NM:0]   mode;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_valid;
  logic          start;
  logic          abort;
  logic [NM-1:0] led;

  kbd_mode_ctrl #(
    .NUM_MODES  (NM),
    .MODE_KEYS  (KEYS),
    .HOLD_IDX   (HOLD),
    .BLINK_HALF (BH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .CLOCK_50 (clk),
    .nReset   (nReset),
    .data     (data),
    .data_en  (data_en),
    .hold_ok  (hold_ok),
    .hold_en  (hold_en),
    .mode     (mode),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_valid(key_valid),
    .start    (start),
    .abort    (abort),
    .led      (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] code;
    logic       ext;
  } key_t;

  key_t key_q[$];
  int   abort_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: m_cur = -1 for IDLE, else the active mode index.
  int cyc     = 0;
  int m_cur   = -1;
  int m_entry = 0;
  int m_act   = 0;
  bit m_brk   = 1'b0;
  bit m_ext   = 1'b0;
  bit m_hprev = 1'b0;

  function automatic logic [7:0] key(input int i);
    logic [NM*8-1:0] k;
    k = KEYS;
    return k[8*i +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_cur   = -1;
      m_brk   = 1'b0;
      m_ext   = 1'b0;
      m_hprev = 1'b0;
    end else begin
      bit make;
      bit mext;
      bit fall;
      int idx;
      int prev_cur;
      cyc++;
      fall     = m_hprev && !hold_en;
      m_hprev  = hold_en;
      make     = 1'b0;
      mext     = 1'b0;
      prev_cur = m_cur;
      if (data_en) begin
        if (m_brk) begin
          m_brk = 1'b0;
          m_ext = 1'b0;
        end else if (data == 8'hF0) begin
          m_brk = 1'b1;
        end else if (data == 8'hE0) begin
          m_ext = 1'b1;
        end else begin
          make  = 1'b1;
          mext  = m_ext;
          m_ext = 1'b0;
        end
      end
      if (m_cur < 0) begin
        if (make) begin
          idx = -1;
          for (int i = NM - 1; i >= 0; i--) if (key(i) == data) idx = i;
          if (idx >= 0 && (idx != HOLD || hold_ok)) m_cur = idx;
        end
      end else if (m_cur == HOLD) begin
        if (make && data == 8'h76) begin
          m_cur = -1;
          abort_q.push_back(cyc);
        end else if (fall) begin
          m_cur = -1;
        end
      end else begin
        if (make && data == 8'h5A) begin
          m_cur = -1;
        end else if (make && data == 8'h76) begin
          m_cur = -1;
          abort_q.push_back(cyc);
        end else if (make) begin
          key_q.push_back('{cyc, data, mext});
        end
`ifdef MODE_TIMEOUT_EN
        else if (!data_en && (cyc - m_act) == TO) begin
          m_cur = -1;
          abort_q.push_back(cyc);
        end
`endif
      end
      if (data_en) m_act = cyc;
      if (m_cur != prev_cur) begin
        m_entry = cyc;
        m_act   = cyc;
      end
    end
  end

  // Monitor: compares registered outputs a few ns after each rising edge.
  always @(posedge clk) begin
    logic [NM:0]   em;
    logic [NM-1:0] el;
    bit            exp_kv;
    bit            exp_ab;
    key_t          e;
    #3;
    em = '0;
    el = '1;
    if (m_cur < 0) begin
      em[0] = 1'b1;
    end else if (m_cur == HOLD) begin
      em[m_cur+1] = 1'b1;
      el          = '0;
      el[HOLD]    = 1'b1;
    end else begin
      em[m_cur+1] = 1'b1;
      el[m_cur]   = (((cyc - m_entry) / BH) % 2) == 1;
    end
    chk("mode", 32'(mode), 32'(em));
    chk("start", 32'(start), 32'(m_cur == HOLD));
    chk("led", 32'(led), 32'(el));

    exp_kv = (key_q.size() > 0) && (key_q[0].cyc <= cyc);
    chk("key_valid", 32'(key_valid), 32'(exp_kv));
    if (exp_kv) begin
      e = key_q.pop_front();
      if (key_valid) begin
        chk("key_code", 32'(key_code), 32'(e.code));
        chk("key_ext", 32'(key_ext), 32'(e.ext));
        $display("key   cyc=%0d code=%h ext=%0d", cyc, key_code, key_ext);
      end
    end

    exp_ab = (abort_q.size() > 0) && (abort_q[0] <= cyc);
    chk("abort", 32'(abort), 32'(exp_ab));
    if (exp_ab) begin
      void'(abort_q.pop_front());
      if (abort) $display("abort cyc=%0d mode=%b", cyc, mode);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data    = b;
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
    data    = 8'($urandom);
  endtask

  task automatic burst3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk); data = a; data_en = 1'b1;
    @(negedge clk); data = b;
    @(negedge clk); data = c;
    @(negedge clk); data_en = 1'b0; data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int         s;
    idle(3);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_key_ext", 32'(key_ext), 32'h0);
    nReset = 1'b1;
    idle(2);

    // Enter mode 1, watch the LED blink, forward one key, leave with ENTER.
    send(key(1)); idle(12); send(8'h16); send(8'h5A);
    // Extended prefix, break filtering, plain make code.
    send(key(1)); send(8'hE0); send(8'h75); send(8'hF0); send(8'h16); send(8'h1E);
    send(8'hE0); send(8'hF0); send(8'h33); send(8'h44); send(8'h5A);
    // Hold mode gated by hold_ok, left by the hold_en falling edge.
    hold_ok = 1'b0; send(key(HOLD)); idle(2);
    hold_ok = 1'b1; send(key(HOLD)); idle(2);
    hold_en = 1'b1; idle(3);
    hold_en = 1'b0; idle(3);
    // ESC abort from an edit mode.
    send(key(2)); send(8'h76); idle(2);
    // ESC together with the hold_en fall.
    send(key(HOLD)); hold_en = 1'b1; idle(3);
    @(negedge clk); data = 8'h76; data_en = 1'b1; hold_en = 1'b0;
    @(negedge clk); data_en = 1'b0;
    idle(2);
    // Back-to-back strobes.
    send(key(0)); burst3(8'h11, 8'h22, 8'h33); send(8'h5A);
    // Inactivity: a long quiet spell, then one restarted midway by a byte.
    send(key(1)); idle(TO + 10); send(8'h5A);
    send(key(1)); idle(50); send(8'h16); idle(TO + 10); send(8'h5A);
    // Asynchronous reset after a pending break.
    send(key(1)); send(8'hF0);
    @(negedge clk); nReset = 1'b0;
    idle(1);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_key_ext", 32'(key_ext), 32'h0);
    idle(1);
    nReset = 1'b1;
    send(key(1)); send(8'h29); send(8'h5A);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if (n % 800 == 400) begin
        data_en = 1'b0;
        idle(TO + 5);
      end
      @(negedge clk);
      nReset  = ($urandom_range(0, 599) != 0);
      data_en = ($urandom_range(0, 99) < 40);
      s = $urandom_range(0, 9);
      if (s <= 2)      b = key($urandom_range(0, NM - 1));
      else if (s == 3) b = 8'h5A;
      else if (s == 4) b = 8'h76;
      else if (s == 5) b = 8'hE0;
      else if (s == 6) b = 8'hF0;
      else             b = 8'($urandom);
      data = b;
      if ($urandom_range(0, 29) == 0) hold_en = ~hold_en;
      if ($urandom_range(0, 99) == 0) hold_ok = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    nReset  = 1'b1;
    data_en = 1'b0;
    idle(5);
    chk("key_q_empty", 32'(key_q.size()), 32'h0);
    chk("abort_q_empty", 32'(abort_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
